// File: rtl/regbank_arbiter_if.sv
// Request/response bundle between NREQ requesters and the shared register bank.
// The master drives the requests; the slave (the arbiter) returns grant and read data.
interface regbank_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       we;
    logic [NREQ-1:0]       lock;
    logic [NREQ*AW-1:0]    addr;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rvalid;
    logic [WIDTH-1:0]      rdata;
    logic                  locked;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata, locked
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata, locked
    );
endinterface

// File: rtl/regbank_arbiter.sv
// DEPTH x WIDTH register bank shared by NREQ requesters through a round-robin
// arbiter; a requester may hold ownership across grants with its lock bit.
module regbank_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    regbank_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(NREQ);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state;
    logic [PW-1:0]    own;
    logic [PW-1:0]    ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic [NREQ-1:0]  gnt_p0;
    logic [PW-1:0]    gnt_idx;
    logic [PW-1:0]    cand;
    logic             gnt_any;
    logic [AW-1:0]    acc_addr;
    logic [WIDTH-1:0] acc_wdata;
    logic             acc_we;
    logic             acc_lock;
    logic             own_req;
    logic             own_lock;

    logic [WIDTH-1:0] rdata_p1;
    logic [NREQ-1:0]  vld_p1;

    // Index arithmetic modulo NREQ, valid for non-power-of-two requester counts.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return s[PW-1:0];
    endfunction

    // Stage p0: combinational grant
    always_comb begin
        gnt_p0  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        if (!rst) begin
            if (state == ST_LOCKED) begin
                if (bus.req[own]) begin
                    gnt_any = 1'b1;
                    gnt_idx = own;
                end
            end else begin
                // Scan from the far end so the last hit is the one nearest ptr.
                for (int k = NREQ - 1; k >= 0; k--) begin
                    cand = wrap_add(ptr, k);
                    if (bus.req[cand]) begin
                        gnt_any = 1'b1;
                        gnt_idx = cand;
                    end
                end
            end
        end
        if (gnt_any) gnt_p0[gnt_idx] = 1'b1;
    end

    assign acc_addr  = bus.addr[gnt_idx*AW +: AW];
    assign acc_wdata = bus.wdata[gnt_idx*WIDTH +: WIDTH];
    assign acc_we    = bus.we[gnt_idx];
    assign acc_lock  = bus.lock[gnt_idx];
    assign own_req   = bus.req[own];
    assign own_lock  = bus.lock[own];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            own   <= '0;
            ptr   <= '0;
        end else if (state == ST_IDLE) begin
            if (gnt_any) begin
                ptr <= wrap_add(gnt_idx, 1);
                if (acc_lock) begin
                    state <= ST_LOCKED;
                    own   <= gnt_idx;
                end
            end
        end else if (!own_req || !own_lock) begin
            // Owner released (or went quiet): hand priority to the next index.
            state <= ST_IDLE;
            ptr   <= wrap_add(own, 1);
        end
    end

    // Stage p1: bank access and registered read response
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
            rdata_p1 <= '0;
            vld_p1   <= '0;
        end else begin
            vld_p1 <= '0;
            if (gnt_any) begin
                if (acc_we) begin
                    mem[acc_addr] <= acc_wdata;
                end else begin
                    rdata_p1 <= mem[acc_addr];
                    vld_p1   <= gnt_p0;
                end
            end
        end
    end

    assign bus.gnt    = gnt_p0;
    assign bus.rvalid = vld_p1;
    assign bus.rdata  = rdata_p1;
    assign bus.locked = (state == ST_LOCKED);
endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: directed scenarios plus randomized traffic checked
// against a rule-level model of arbitration, locking and the register bank.
module tb_regbank_arbiter;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk;
    logic rst;
    logic [NREQ-1:0]       req_v;
    logic [NREQ-1:0]       we_v;
    logic [NREQ-1:0]       lock_v;
    logic [NREQ*AW-1:0]    addr_v;
    logic [NREQ*WIDTH-1:0] wdata_v;

    int checks = 0;
    int errors = 0;

    logic [NREQ-1:0] obs_gnt;
    logic [NREQ-1:0] exp_gnt;

    // Reference model state
    logic [WIDTH-1:0] m_mem [DEPTH];
    int               m_ptr;
    bit               m_locked;
    int               m_own;
    logic [NREQ-1:0]  m_rvalid;
    logic [WIDTH-1:0] m_rdata;

    regbank_if #(.WIDTH(WIDTH), .NREQ(NREQ), .DEPTH(DEPTH)) bus ();

    assign bus.req   = req_v;
    assign bus.we    = we_v;
    assign bus.lock  = lock_v;
    assign bus.addr  = addr_v;
    assign bus.wdata = wdata_v;

    regbank_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_pick();
        if (rst) return -1;
        if (m_locked) return req_v[m_own] ? m_own : -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req_v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] model_gnt();
        int g;
        logic [NREQ-1:0] e;
        g = model_pick();
        e = '0;
        if (g >= 0) e[g] = 1'b1;
        return e;
    endfunction

    task automatic model_update();
        int g;
        logic [AW-1:0] a;
        g = model_pick();
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) m_mem[j] = '0;
            m_rdata  = '0;
            m_rvalid = '0;
            m_ptr    = 0;
            m_locked = 0;
            m_own    = 0;
            return;
        end
        m_rvalid = '0;
        if (g >= 0) begin
            a = addr_v[g*AW +: AW];
            if (we_v[g]) m_mem[a] = wdata_v[g*WIDTH +: WIDTH];
            else begin
                m_rdata     = m_mem[a];
                m_rvalid[g] = 1'b1;
            end
        end
        if (m_locked) begin
            if (!req_v[m_own] || !lock_v[m_own]) begin
                m_locked = 0;
                m_ptr    = (m_own + 1) % NREQ;
            end
        end else if (g >= 0) begin
            m_ptr = (g + 1) % NREQ;
            if (lock_v[g]) begin
                m_locked = 1;
                m_own    = g;
            end
        end
    endtask

    // Called just after a falling edge with inputs set; returns at the next falling edge.
    task automatic tick();
        #1;
        obs_gnt = bus.gnt;
        exp_gnt = model_gnt();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_v   = '0;
        we_v    = '0;
        lock_v  = '0;
        addr_v  = '0;
        wdata_v = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst    = 1'b1;
        req_v  = 4'b1111;
        lock_v = 4'b1111;
        tick();
        checks++; if (obs_gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got=%b exp=%b", obs_gnt, 4'b0000); end
        tick();
        checks++; if (obs_gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt2 got=%b exp=%b", obs_gnt, 4'b0000); end
        checks++; if (bus.rvalid !== 4'b0000) begin errors++; $display("FAIL rst_rvalid got=%b exp=%b", bus.rvalid, 4'b0000); end
        checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got=%h exp=%h", bus.rdata, 8'h00); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL rst_locked got=%b exp=%b", bus.locked, 1'b0); end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_read_after_reset();
        do_reset();
        req_v       = 4'b0001;
        addr_v[2:0] = 3'd3;
        tick();
        checks++; if (obs_gnt !== 4'b0001) begin errors++; $display("FAIL rar_gnt got=%b exp=%b", obs_gnt, 4'b0001); end
        checks++; if (bus.rvalid !== 4'b0001) begin errors++; $display("FAIL rar_rvalid got=%b exp=%b", bus.rvalid, 4'b0001); end
        checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL rar_rdata got=%h exp=%h", bus.rdata, 8'h00); end
        idle_inputs();
        tick();
        checks++; if (obs_gnt !== 4'b0000) begin errors++; $display("FAIL rar_idle_gnt got=%b exp=%b", obs_gnt, 4'b0000); end
        checks++; if (bus.rvalid !== 4'b0000) begin errors++; $display("FAIL rar_idle_rvalid got=%b exp=%b", bus.rvalid, 4'b0000); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req_v = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            addr_v = 12'($urandom);
            tick();
            checks++; if (obs_gnt !== seq[c]) begin errors++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", c, obs_gnt, seq[c]); end
            checks++; if (bus.rvalid !== seq[c]) begin errors++; $display("FAIL rr_rvalid[%0d] got=%b exp=%b", c, bus.rvalid, seq[c]); end
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        do_reset();
        req_v          = 4'b0100;
        we_v           = 4'b0100;
        addr_v[8:6]    = 3'd5;
        wdata_v[23:16] = 8'hA5;
        tick();
        checks++; if (obs_gnt !== 4'b0100) begin errors++; $display("FAIL wr_gnt got=%b exp=%b", obs_gnt, 4'b0100); end
        checks++; if (bus.rvalid !== 4'b0000) begin errors++; $display("FAIL wr_rvalid got=%b exp=%b", bus.rvalid, 4'b0000); end
        idle_inputs();
        req_v       = 4'b0010;
        addr_v[5:3] = 3'd5;
        tick();
        checks++; if (obs_gnt !== 4'b0010) begin errors++; $display("FAIL rd_gnt got=%b exp=%b", obs_gnt, 4'b0010); end
        checks++; if (bus.rvalid !== 4'b0010) begin errors++; $display("FAIL rd_rvalid got=%b exp=%b", bus.rvalid, 4'b0010); end
        checks++; if (bus.rdata !== 8'hA5) begin errors++; $display("FAIL rd_rdata got=%h exp=%h", bus.rdata, 8'hA5); end
        idle_inputs();
        tick();
        checks++; if (bus.rdata !== 8'hA5) begin errors++; $display("FAIL rd_hold got=%h exp=%h", bus.rdata, 8'hA5); end
    endtask

    task automatic test_lock();
        do_reset();
        req_v = 4'b0001;
        tick();
        checks++; if (obs_gnt !== 4'b0001) begin errors++; $display("FAIL lk_pre_gnt got=%b exp=%b", obs_gnt, 4'b0001); end
        req_v  = 4'b1111;
        lock_v = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (obs_gnt !== 4'b0010) begin errors++; $display("FAIL lk_gnt[%0d] got=%b exp=%b", c, obs_gnt, 4'b0010); end
            checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL lk_locked[%0d] got=%b exp=%b", c, bus.locked, 1'b1); end
        end
        lock_v = 4'b0000;
        tick();
        checks++; if (obs_gnt !== 4'b0010) begin errors++; $display("FAIL lk_rel_gnt got=%b exp=%b", obs_gnt, 4'b0010); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL lk_rel_locked got=%b exp=%b", bus.locked, 1'b0); end
        tick();
        checks++; if (obs_gnt !== 4'b0100) begin errors++; $display("FAIL lk_next_gnt got=%b exp=%b", obs_gnt, 4'b0100); end
        idle_inputs();
    endtask

    task automatic test_reset_in_lock();
        do_reset();
        req_v       = 4'b0001;
        we_v        = 4'b0001;
        addr_v[2:0] = 3'd2;
        wdata_v[7:0] = 8'h3C;
        tick();
        idle_inputs();
        req_v        = 4'b1000;
        lock_v       = 4'b1000;
        addr_v[11:9] = 3'd2;
        tick();
        checks++; if (obs_gnt !== 4'b1000) begin errors++; $display("FAIL rl_gnt got=%b exp=%b", obs_gnt, 4'b1000); end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL rl_locked got=%b exp=%b", bus.locked, 1'b1); end
        checks++; if (bus.rdata !== 8'h3C) begin errors++; $display("FAIL rl_rdata got=%h exp=%h", bus.rdata, 8'h3C); end
        rst = 1'b1;
        tick();
        checks++; if (obs_gnt !== 4'b0000) begin errors++; $display("FAIL rl_rst_gnt got=%b exp=%b", obs_gnt, 4'b0000); end
        checks++; if (bus.rvalid !== 4'b0000) begin errors++; $display("FAIL rl_rst_rvalid got=%b exp=%b", bus.rvalid, 4'b0000); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL rl_rst_locked got=%b exp=%b", bus.locked, 1'b0); end
        rst = 1'b0;
        idle_inputs();
        req_v       = 4'b1111;
        addr_v[2:0] = 3'd2;
        tick();
        checks++; if (obs_gnt !== 4'b0001) begin errors++; $display("FAIL rl_first_gnt got=%b exp=%b", obs_gnt, 4'b0001); end
        checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL rl_cleared got=%h exp=%h", bus.rdata, 8'h00); end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(0, 49) == 0);
            req_v   = 4'($urandom);
            we_v    = 4'($urandom);
            lock_v  = 4'($urandom) & 4'($urandom);
            addr_v  = 12'($urandom);
            wdata_v = 32'($urandom);
            tick();
            checks++; if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt[%0d] got=%b exp=%b", c, obs_gnt, exp_gnt); end
            checks++; if ($countones(obs_gnt) > 1) begin errors++; $display("FAIL rnd_onehot[%0d] got=%b exp=<=1 bit", c, obs_gnt); end
            checks++; if (bus.rvalid !== m_rvalid) begin errors++; $display("FAIL rnd_rvalid[%0d] got=%b exp=%b", c, bus.rvalid, m_rvalid); end
            checks++; if (bus.rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", c, bus.rdata, m_rdata); end
            checks++; if (bus.locked !== m_locked) begin errors++; $display("FAIL rnd_locked[%0d] got=%b exp=%b", c, bus.locked, m_locked); end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_ptr    = 0;
        m_locked = 0;
        m_own    = 0;
        m_rvalid = '0;
        m_rdata  = '0;
        for (int j = 0; j < DEPTH; j++) m_mem[j] = '0;
        @(negedge clk);
        test_reset();
        test_read_after_reset();
        test_round_robin();
        test_write_read();
        test_lock();
        test_reset_in_lock();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
